// File: rtl/rx_cmd_decoder_pkg.sv
// rx_cmd_decoder_pkg
//   Shared types and constants for the RX command decoder: FSM state
//   encoding, decoder mode, ASCII command/number constants, threshold and
//   accumulator widths, and small byte-classification helpers.
package rx_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DECODE = 2'd3
    } state_t;

    typedef enum logic {
        MODE_CMD = 1'b0,
        MODE_NUM = 1'b1
    } mode_t;

    localparam int THRESH_W   = 9;   // threshold in cm, up to 511
    localparam int ACC_W      = 10;  // three decimal digits, max 999
    localparam int CNT_W      = 2;
    localparam int MAX_DIGITS = 3;

    localparam logic [7:0] ASC_U  = 8'h55;
    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_C  = 8'h43;
    localparam logic [7:0] ASC_D  = 8'h44;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;

    // Fold lower-case letters onto upper case; everything else passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASC_CR) || (b == ASC_LF);
    endfunction

endpackage

// File: rtl/rx_cmd_decoder_ascii_dec_acc.sv
// ascii_dec_acc
//   Decimal entry accumulator for the threshold command. Holds the running
//   value and digit count, and presents the value clamped to THRESH_MAX.
//   Ports:
//     clk, reset   clock / async active-low reset
//     clr          start a new number (acc = 0, count = 0)
//     dig_we       append one decimal digit
//     dig          digit value 0..9
//     full         already holding the maximum number of digits
//     empty        no digit entered yet
//     thresh_val   min(acc, THRESH_MAX)
module ascii_dec_acc
    import rx_cmd_decoder_pkg::*;
#(
    parameter int THRESH_MAX = 400
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                dig_we,
    input  logic [3:0]          dig,
    output logic                full,
    output logic                empty,
    output logic [THRESH_W-1:0] thresh_val
);

    localparam logic [ACC_W-1:0]    MAX_ACC = ACC_W'(THRESH_MAX);
    localparam logic [THRESH_W-1:0] MAX_THR = THRESH_W'(THRESH_MAX);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // The caller never appends past MAX_DIGITS, so acc stays <= 999.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (dig_we) begin
            acc <= acc * ACC_W'(10) + ACC_W'(dig);
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign full       = (cnt == CNT_W'(MAX_DIGITS));
    assign empty      = (cnt == '0);
    assign thresh_val = (acc > MAX_ACC) ? MAX_THR : acc[THRESH_W-1:0];

endmodule

// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder
//   Pulls bytes from an RX FIFO (one every 4 clocks), optionally echoes them
//   to a TX FIFO, and decodes single-letter commands plus a "D<digits><EOL>"
//   threshold entry.
//   Ports:
//     clk, reset          clock / async active-low reset
//     rx_empty, rx_data   RX FIFO status / read data (valid cycle after rx_re)
//     rx_re               RX FIFO read strobe
//     tx_full             TX FIFO full flag
//     tx_data, tx_we      echo byte / TX write strobe
//     sonic_start, run_toggle, clear, thresh_upd, cmd_error
//                         one-cycle action pulses, registered after DECODE
//     thresh              current distance threshold in cm
module rx_cmd_decoder
    import rx_cmd_decoder_pkg::*;
#(
    parameter int ECHO_EN    = 1,
    parameter int THRESH_MAX = 400,
    parameter int THRESH_RST = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_empty,
    input  logic [7:0]          rx_data,
    output logic                rx_re,
    input  logic                tx_full,
    output logic [7:0]          tx_data,
    output logic                tx_we,
    output logic                sonic_start,
    output logic                run_toggle,
    output logic                clear,
    output logic [THRESH_W-1:0] thresh,
    output logic                thresh_upd,
    output logic                cmd_error
);

    state_t                state;
    mode_t                 mode;
    logic [7:0]            rx_byte;
    logic [7:0]            up;
    logic                  acc_full, acc_empty;
    logic [THRESH_W-1:0]   acc_thresh;

    logic d_sonic, d_run, d_clear, d_upd, d_err;
    logic d_num_start, d_dig_we, d_to_cmd;

    assign up = to_upper(rx_byte);

    // Action decode of the captured byte; only consumed in ST_DECODE.
    always_comb begin
        d_sonic     = 1'b0;
        d_run       = 1'b0;
        d_clear     = 1'b0;
        d_upd       = 1'b0;
        d_err       = 1'b0;
        d_num_start = 1'b0;
        d_dig_we    = 1'b0;
        d_to_cmd    = 1'b0;
        if (mode == MODE_CMD) begin
            case (up)
                ASC_U:          d_sonic     = 1'b1;
                ASC_R:          d_run       = 1'b1;
                ASC_C:          d_clear     = 1'b1;
                ASC_D:          d_num_start = 1'b1;
                ASC_CR, ASC_LF: ;
                default:        d_err       = 1'b1;
            endcase
        end else begin
            if (is_digit(rx_byte)) begin
                if (acc_full) begin
                    d_err    = 1'b1;
                    d_to_cmd = 1'b1;
                end else begin
                    d_dig_we = 1'b1;
                end
            end else begin
                // Both EOL and garbage leave number entry.
                d_to_cmd = 1'b1;
                if (is_eol(rx_byte) && !acc_empty) d_upd = 1'b1;
                else                               d_err = 1'b1;
            end
        end
    end

    ascii_dec_acc #(
        .THRESH_MAX (THRESH_MAX)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clr        ((state == ST_DECODE) && d_num_start),
        .dig_we     ((state == ST_DECODE) && d_dig_we),
        .dig        (rx_byte[3:0]),
        .full       (acc_full),
        .empty      (acc_empty),
        .thresh_val (acc_thresh)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            mode        <= MODE_CMD;
            rx_byte     <= '0;
            rx_re       <= 1'b0;
            tx_we       <= 1'b0;
            tx_data     <= '0;
            sonic_start <= 1'b0;
            run_toggle  <= 1'b0;
            clear       <= 1'b0;
            thresh_upd  <= 1'b0;
            cmd_error   <= 1'b0;
            thresh      <= THRESH_W'(THRESH_RST);
        end else begin
            rx_re       <= 1'b0;
            tx_we       <= 1'b0;
            sonic_start <= 1'b0;
            run_toggle  <= 1'b0;
            clear       <= 1'b0;
            thresh_upd  <= 1'b0;
            cmd_error   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // rx_re is registered, so it is high exactly while in FETCH.
                    if (!rx_empty) begin
                        state <= ST_FETCH;
                        rx_re <= 1'b1;
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    rx_byte <= rx_data;
                    state   <= ST_DECODE;
                end
                ST_DECODE: begin
                    state       <= ST_IDLE;
                    sonic_start <= d_sonic;
                    run_toggle  <= d_run;
                    clear       <= d_clear;
                    thresh_upd  <= d_upd;
                    cmd_error   <= d_err;
                    if (d_num_start) mode   <= MODE_NUM;
                    if (d_to_cmd)    mode   <= MODE_CMD;
                    if (d_upd)       thresh <= acc_thresh;
                    // A full TX FIFO simply loses the echo.
                    if (ECHO_EN != 0 && !tx_full) begin
                        tx_we   <= 1'b1;
                        tx_data <= rx_byte;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
module tb_rx_cmd_decoder;

    localparam int T_MAX = 400;
    localparam int T_RST = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_re;
    logic       tx_full = 1'b0;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       sonic_start, run_toggle, clear, thresh_upd, cmd_error;
    logic [8:0] thresh;

    int total = 0;
    int bad   = 0;

    rx_cmd_decoder dut (
        .clk         (clk),
        .reset       (rst_n),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rx_re       (rx_re),
        .tx_full     (tx_full),
        .tx_data     (tx_data),
        .tx_we       (tx_we),
        .sonic_start (sonic_start),
        .run_toggle  (run_toggle),
        .clear       (clear),
        .thresh      (thresh),
        .thresh_upd  (thresh_upd),
        .cmd_error   (cmd_error)
    );

    always #5 clk = ~clk;

    // Per-byte observation summary: counts of each strobe, echoed byte and
    // latency from the read strobe to the first output pulse.
    typedef struct packed {
        logic [3:0] n_re, n_sonic, n_run, n_clr, n_upd, n_err, n_we;
        logic [7:0] echo;
        logic [3:0] lat;
    } obs_t;

    // Reference model state: command text semantics.
    bit m_num;
    int m_digits;
    int m_val;
    int m_thresh;

    task automatic model_reset();
        m_num = 0; m_digits = 0; m_val = 0; m_thresh = T_RST;
    endtask

    function automatic obs_t model_step(input logic [7:0] b, input bit full);
        obs_t e;
        int   c;
        e = '0;
        c = (b >= "a" && b <= "z") ? int'(b) - 32 : int'(b);
        if (!m_num) begin
            if (c == "U") e.n_sonic = 1;
            else if (c == "R") e.n_run = 1;
            else if (c == "C") e.n_clr = 1;
            else if (c == "D") begin m_num = 1; m_digits = 0; m_val = 0; end
            else if (c != 13 && c != 10) e.n_err = 1;
        end else if (c >= "0" && c <= "9") begin
            if (m_digits == 3) begin e.n_err = 1; m_num = 0; end
            else begin m_val = m_val * 10 + (c - "0"); m_digits++; end
        end else if (c == 13 || c == 10) begin
            if (m_digits > 0) begin
                m_thresh = (m_val > T_MAX) ? T_MAX : m_val;
                e.n_upd = 1;
            end else e.n_err = 1;
            m_num = 0;
        end else begin
            e.n_err = 1; m_num = 0;
        end
        e.n_re = 1;
        if (!full) begin e.n_we = 1; e.echo = b; end
        if (!full || e.n_sonic || e.n_run || e.n_clr || e.n_upd || e.n_err) e.lat = 3;
        return e;
    endfunction

    // Acts as a one-entry RX FIFO holding b and records what the DUT does
    // over a fixed 10-cycle window.
    task automatic send_byte(input logic [7:0] b, input bit full, output obs_t o);
        int  re_cyc;
        bit  seen;
        o = '0; re_cyc = -1; seen = 0;
        tx_full  = full;
        rx_data  = ~b;
        rx_empty = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rx_re) begin
                o.n_re = o.n_re + 1;
                if (re_cyc < 0) re_cyc = c;
                rx_empty = 1'b1;
            end else if (re_cyc >= 0 && c == re_cyc + 1) begin
                rx_data = b;
            end
            if (sonic_start) o.n_sonic = o.n_sonic + 1;
            if (run_toggle)  o.n_run   = o.n_run + 1;
            if (clear)       o.n_clr   = o.n_clr + 1;
            if (thresh_upd)  o.n_upd   = o.n_upd + 1;
            if (cmd_error)   o.n_err   = o.n_err + 1;
            if (tx_we) begin o.n_we = o.n_we + 1; o.echo = tx_data; end
            if (!seen && (sonic_start || run_toggle || clear || thresh_upd || cmd_error || tx_we)) begin
                seen  = 1;
                o.lat = 4'(c - re_cyc);
            end
        end
        rx_empty = 1'b1;
        tx_full  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rx_re, tx_we, sonic_start, run_toggle, clear, thresh_upd, cmd_error} !== 7'b0) begin
            bad++; $display("FAIL reset_pulses got=%b want=0", {rx_re, tx_we, sonic_start, run_toggle, clear, thresh_upd, cmd_error});
        end
        total++;
        if (thresh !== 9'(T_RST)) begin bad++; $display("FAIL reset_thresh got=%0d want=%0d", thresh, T_RST); end
        total++;
        if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_txdata got=%h want=00", tx_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cmd_u();
        obs_t o, e;
        send_byte("U", 0, o);
        e = model_step("U", 0);
        total++;
        if (o !== e) begin bad++; $display("FAIL cmd_u got=%h want=%h", o, e); end
    endtask

    task automatic test_threshold(input string s, input string tag);
        obs_t o, e;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 0, o);
            e = model_step(s[i], 0);
            total++;
            if (o !== e) begin bad++; $display("FAIL %s byte%0d got=%h want=%h", tag, i, o, e); end
        end
        total++;
        if (thresh !== 9'(m_thresh)) begin bad++; $display("FAIL %s thresh got=%0d want=%0d", tag, thresh, m_thresh); end
    endtask

    task automatic test_bad_seq();
        obs_t  o, e;
        string s = "DXc";
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 0, o);
            e = model_step(s[i], 0);
            total++;
            if (o !== e) begin bad++; $display("FAIL bad_seq byte%0d got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_tx_full();
        obs_t o, e;
        send_byte("r", 1, o);
        e = model_step("r", 1);
        total++;
        if (o !== e) begin bad++; $display("FAIL tx_full got=%h want=%h", o, e); end
    endtask

    task automatic test_reset_mid();
        obs_t  o, e;
        string s = "D12";
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 0, o);
            e = model_step(s[i], 0);
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_mid byte%0d got=%h want=%h", i, o, e); end
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (thresh !== 9'(T_RST)) begin bad++; $display("FAIL reset_mid_async got=%0d want=%0d", thresh, T_RST); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h0D, 0, o);
        e = model_step(8'h0D, 0);
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_mid_cr got=%h want=%h", o, e); end
        total++;
        if (thresh !== 9'(m_thresh)) begin bad++; $display("FAIL reset_mid_thresh got=%0d want=%0d", thresh, m_thresh); end
    endtask

    task automatic test_back_to_back();
        int n_re = 0, n_clr = 0, n_we = 0, n_idle_re = 0;
        obs_t e;
        rx_data  = "C";
        rx_empty = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (rx_re) n_re++;
            if (clear) n_clr++;
            if (tx_we) n_we++;
        end
        rx_empty = 1'b1;
        for (int k = 0; k < 3; k++) e = model_step("C", 0);
        total++;
        if ({n_re, n_clr, n_we} !== {32'd3, 32'(e.n_clr) * 3, 32'd3}) begin
            bad++; $display("FAIL back_to_back got re=%0d clr=%0d we=%0d want 3 each", n_re, n_clr, n_we);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rx_re) n_idle_re++;
        end
        total++;
        if (n_idle_re !== 0) begin bad++; $display("FAIL idle_no_read got=%0d want=0", n_idle_re); end
    endtask

    task automatic test_random();
        obs_t  o, e;
        string alpha = "UuRrCcDdD0123456789\r\nX?z";
        logic [7:0] b;
        bit         full;
        for (int i = 0; i < 80; i++) begin
            b    = alpha[$urandom_range(alpha.len() - 1, 0)];
            full = ($urandom_range(3, 0) == 0);
            send_byte(b, full, o);
            e = model_step(b, full);
            total++;
            if (o !== e) begin bad++; $display("FAIL random%0d byte=%h got=%h want=%h", i, b, o, e); end
            total++;
            if (thresh !== 9'(m_thresh)) begin bad++; $display("FAIL random%0d thresh got=%0d want=%0d", i, thresh, m_thresh); end
        end
    endtask

    initial begin
        test_reset();
        test_cmd_u();
        test_threshold("D250\r", "d250");
        test_threshold("D999\n", "d999");
        test_threshold("D1234\r", "d1234");
        test_threshold("D\r", "d_empty");
        test_bad_seq();
        test_tx_full();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 SHALL have parameter ECHO_EN, default 1, meaning received bytes are echoed to the TX FIFO when 1.
REQ-002 SHALL have parameter THRESH_MAX, default 400, meaning the clamp ceiling for the distance threshold in cm.
REQ-003 SHALL have parameter THRESH_RST, default 100, meaning the threshold value after reset.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows:
  clk  input  1  system clock; all state changes on its rising edge
  reset  input  1  asynchronous, active-low reset
  rx_empty  input  1  RX FIFO empty flag
  rx_data  input  8  RX FIFO read data, valid the cycle after rx_re
  rx_re  output  1  RX FIFO read strobe, one cycle per byte
  tx_full  input  1  TX FIFO full flag
  tx_data  output  8  echo byte
  tx_we  output  1  TX FIFO write strobe
  sonic_start  output  1  one-cycle pulse requesting an ultrasonic measurement
  run_toggle  output  1  one-cycle pulse
  clear  output  1  one-cycle pulse
  thresh  output  9  distance threshold in cm
  thresh_upd  output  1  one-cycle pulse when thresh is loaded
  cmd_error  output  1  one-cycle pulse on an illegal byte or sequence

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, WAIT, DECODE.
- IDLE -> FETCH when rx_empty=0.
- FETCH -> WAIT unconditionally.
- WAIT -> DECODE unconditionally.
- DECODE -> IDLE unconditionally.
REQ-006 SHALL assert rx_re in FETCH only, exactly one cycle per byte; it SHALL never assert while rx_empty=1.
REQ-007 SHALL capture rx_data into an internal byte register in WAIT; throughput SHALL be one byte per 4 clocks.
REQ-008 SHALL keep a mode flag: CMD (after reset) or NUM.
REQ-009 SHALL apply these actions in DECODE with mode CMD:
- 'U'/'u' -> sonic_start.
- 'R'/'r' -> run_toggle.
- 'C'/'c' -> clear.
- 'D'/'d' -> mode NUM, accumulator=0, digit count=0.
- 0x0D/0x0A -> ignored, no pulse.
- any other byte -> cmd_error.
REQ-010 SHALL apply these actions in DECODE with mode NUM:
- '0'..'9' -> acc = acc*10 + (byte-0x30), digit count +1.
- A 4th digit -> cmd_error, mode CMD, thresh unchanged.
REQ-011 SHALL, on CR/LF in NUM with count>=1, set thresh = min(acc, THRESH_MAX), pulse thresh_upd, and return to mode CMD.
REQ-012 SHALL, on CR/LF in NUM with count=0, pulse cmd_error and return to mode CMD.
REQ-013 SHALL, on any other byte in NUM, pulse cmd_error, return to mode CMD, and leave thresh unchanged.
REQ-014 SHALL use a 10-bit accumulator; 999 is the maximum, so no overflow is possible.
REQ-015 SHALL make all action outputs one-cycle registered pulses, asserted the cycle after DECODE, with at most one pulse per byte.
REQ-016 SHALL, when ECHO_EN=1 and tx_full=0 in DECODE, assert tx_we for one cycle with tx_data = the received byte.
REQ-017 SHALL drop the echo when tx_full=1, with no retry and no effect on decoding.
REQ-018 SHALL tie tx_we to 0 when ECHO_EN=0.
REQ-019 SHALL ignore rx_empty rising during WAIT/DECODE; the byte already read is still processed.

Reset
REQ-020 SHALL, while reset=0, immediately force:
- state IDLE, mode CMD, accumulator 0, count 0;
- rx_re, tx_we, sonic_start, run_toggle, clear, thresh_upd, cmd_error = 0;
- tx_data = 0x00, thresh = THRESH_RST.
REQ-021 SHALL discard any partially entered number on reset mid-sequence, with no pulse.
REQ-022 SHALL, after reset release, begin reading on the first rising edge with rx_empty=0.

Structure
REQ-023 SHALL place the state encoding, ASCII constants ('U','R','C','D', CR, LF, '0', '9') and the threshold width in a shared package.
REQ-024 SHALL use one sub-module, ascii_dec_acc, holding the accumulator, digit count, and overflow/clamp logic; the FSM stays in the top.

Verification
REQ-025 SHALL cover: byte 'U' with rx_empty=0 -> exactly one rx_re, sonic_start high 1 cycle, tx_we with tx_data=0x55.
REQ-026 SHALL cover: "D250\r" -> thresh=250, one thresh_upd pulse, no cmd_error.
REQ-027 SHALL cover: "D999\n" -> thresh=400 (clamped); "D1234\r" -> cmd_error on '4', thresh unchanged; the trailing '\r' is ignored.
REQ-028 SHALL cover: "DX" -> cmd_error on 'X', mode CMD; a following 'c' -> clear pulse.
REQ-029 SHALL cover: tx_full=1 during "r" -> run_toggle pulses, tx_we stays 0.
REQ-030 SHALL cover: reset=0 after "D12" -> thresh=100; then "\r" -> ignored, no pulses.
